// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, bus layouts and divider states.
package exe_defs;

   localparam int ID_EXE_W      = 117;
   localparam int EXE_MEM_W     = 58;
   localparam int DIV_STEPS_DEF = 32;
   localparam int ADDR_W_DEF    = 10;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_OR   = 5'd3,
      OP_XOR  = 5'd4,
      OP_NOR  = 5'd5,
      OP_SLT  = 5'd6,
      OP_SLTU = 5'd7,
      OP_SLL  = 5'd8,
      OP_SRL  = 5'd9,
      OP_SRA  = 5'd10,
      OP_LUI  = 5'd11,
      OP_MUL  = 5'd12,
      OP_DIV  = 5'd13,
      OP_DIVU = 5'd14,
      OP_REM  = 5'd15,
      OP_REMU = 5'd16
   } alu_op_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   typedef struct packed {
      alu_op_t     alu_op;
      logic        read;
      logic        write;
      logic [1:0]  len;
      logic        un;
      logic [10:0] wb_through;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] store_val;
   } id_exe_t;

   function automatic logic is_div_op(input alu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, STEPS cycles after start.
module div_iter
   import exe_defs::*;
#(
   parameter int STEPS = DIV_STEPS_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int CW = $clog2(STEPS);

   logic [CW-1:0] cnt;
   logic [31:0]   q_r;
   logic [31:0]   r_r;
   logic [31:0]   d_r;
   logic [32:0]   r_shift;
   logic [32:0]   diff;

   // Partial remainder stays below the divisor, so 33 bits hold the shifted trial value.
   assign r_shift = {r_r, q_r[31]};
   assign diff    = r_shift - {1'b0, d_r};
   assign done    = busy && (cnt == CW'(STEPS - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy <= 1'b0;
         cnt  <= '0;
         q_r  <= '0;
         r_r  <= '0;
         d_r  <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
         q_r  <= dividend;
         r_r  <= '0;
         d_r  <= divisor;
      end else if (busy) begin
         if (!diff[32]) begin
            r_r <= diff[31:0];
            q_r <= {q_r[30:0], 1'b1};
         end else begin
            r_r <= r_shift[31:0];
            q_r <= {q_r[30:0], 1'b0};
         end
         cnt <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

   assign quotient  = q_r;
   assign remainder = r_r;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, iterative divide/remainder, address generation.
// Handshake: a transfer happens on a clock edge where valid and the receiver's allowin are both high.
module exe_stage
   import exe_defs::*;
#(
   parameter int DIV_STEPS = DIV_STEPS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                id_valid,
   input  logic [ID_EXE_W-1:0] ID_EXE_BUS,
   output logic                exe_allowin,
   input  logic                mem_allowin,
   input  logic                flush,
   output logic                exe_to_mem_valid,
   output logic [47+ADDR_W:0]  EXE_MEM_BUS,
   output logic [1:0]          div_state_dbg
);

   id_exe_t    ir;
   logic       exe_valid_r;
   div_state_t state;

   logic        is_div;
   logic        ready_go;
   logic        accept;
   logic        div_start;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        signed_div;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic        div_zero;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [31:0] addr_sum;
   logic [31:0] op_res;
   logic [31:0] exe_result;

   assign is_div           = is_div_op(ir.alu_op);
   assign ready_go         = !is_div || (state == DIV_DONE);
   assign exe_allowin      = !exe_valid_r || (ready_go && mem_allowin);
   assign exe_to_mem_valid = exe_valid_r && ready_go;
   assign accept           = id_valid && exe_allowin && !flush;
   assign div_state_dbg    = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exe_valid_r <= 1'b0;
         ir          <= '0;
      end else if (flush) begin
         exe_valid_r <= 1'b0;
      end else if (accept) begin
         exe_valid_r <= 1'b1;
         ir          <= id_exe_t'(ID_EXE_BUS);
      end else if (ready_go && mem_allowin) begin
         exe_valid_r <= 1'b0;
      end
   end

   // Divider sequencing; DONE holds the result until memory takes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= DIV_IDLE;
      end else if (flush) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: if (exe_valid_r && is_div) state <= DIV_RUN;
            DIV_RUN:  if (div_busy && div_done) state <= DIV_DONE;
            DIV_DONE: if (mem_allowin) state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

   assign div_start = (state == DIV_IDLE) && exe_valid_r && is_div && !flush;

   // Magnitudes go into the unsigned core; signs are restored on the way out.
   assign signed_div = (ir.alu_op == OP_DIV) || (ir.alu_op == OP_REM);
   assign a_neg      = signed_div && ir.src1[31];
   assign b_neg      = signed_div && ir.src2[31];
   assign a_abs      = a_neg ? (32'd0 - ir.src1) : ir.src1;
   assign b_abs      = b_neg ? (32'd0 - ir.src2) : ir.src2;
   assign div_zero   = (ir.src2 == 32'd0);
   assign quot_fix   = div_zero ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? (32'd0 - div_q) : div_q);
   assign rem_fix    = div_zero ? ir.src1 : (a_neg ? (32'd0 - div_r) : div_r);

   div_iter #(
      .STEPS(DIV_STEPS)
   ) u_div (
      .clk      (clk),
      .resetn   (resetn),
      .start    (div_start),
      .abort    (flush),
      .dividend (a_abs),
      .divisor  (b_abs),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q),
      .remainder(div_r)
   );

   assign addr_sum = ir.src1 + ir.src2;

   always_comb begin
      op_res = 32'd0;
      case (ir.alu_op)
         OP_ADD:  op_res = addr_sum;
         OP_SUB:  op_res = ir.src1 - ir.src2;
         OP_AND:  op_res = ir.src1 & ir.src2;
         OP_OR:   op_res = ir.src1 | ir.src2;
         OP_XOR:  op_res = ir.src1 ^ ir.src2;
         OP_NOR:  op_res = ~(ir.src1 | ir.src2);
         OP_SLT:  op_res = {31'd0, $signed(ir.src1) < $signed(ir.src2)};
         OP_SLTU: op_res = {31'd0, ir.src1 < ir.src2};
         OP_SLL:  op_res = ir.src1 << ir.src2[4:0];
         OP_SRL:  op_res = ir.src1 >> ir.src2[4:0];
         OP_SRA:  op_res = $signed(ir.src1) >>> ir.src2[4:0];
         OP_LUI:  op_res = ir.src2 << 16;
         OP_MUL:  op_res = ir.src1 * ir.src2;
         OP_DIV,
         OP_DIVU: op_res = quot_fix;
         OP_REM,
         OP_REMU: op_res = rem_fix;
         default: op_res = 32'd0;
      endcase
   end

   assign exe_result  = ir.write ? ir.store_val : op_res;
   assign EXE_MEM_BUS = {ir.read, ir.write, ir.len, ir.un, ir.wb_through,
                         addr_sum[ADDR_W-1:0], exe_result};

endmodule
